// File: rtl/envelope_sequencer.sv
// ADSR envelope controller: steps a fixed-point level once per sample_clock rise.
// Optional gate-edge retrigger enabled by defining ENVELOPE_RETRIGGER_EN.
module envelope_sequencer #(
  parameter int VOLBITS  = 8,
  parameter int FRACBITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_clock,
  input  logic                          gate,
  input  logic [VOLBITS+FRACBITS-1:0]   attack_rate,
  input  logic [VOLBITS+FRACBITS-1:0]   decay_rate,
  input  logic [VOLBITS-1:0]            sustain_level,
  input  logic [VOLBITS+FRACBITS-1:0]   release_rate,
  output logic [VOLBITS-1:0]            volume,
  output logic [2:0]                    state,
  output logic                          busy
);
  localparam int LW = VOLBITS + FRACBITS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } st_e;

  logic          sc_q, sc_d;
  logic [LW-1:0] level_q, level_d;
  st_e           st_q, st_d;
  logic          busy_q, busy_d;
  logic          tick, retrig;
  logic [LW-1:0] sus_full;
  logic [LW:0]   sum, dec, rel;

`ifdef ENVELOPE_RETRIGGER_EN
  logic gate_q, gate_d;
  logic pend_q, pend_d;

  always_comb begin
    gate_d = gate;
    pend_d = pend_q;
    if (tick)            pend_d = 1'b0;
    if (gate && !gate_q) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      gate_q <= gate_d;
      pend_q <= pend_d;
    end
  end

  assign retrig = pend_q;
`else
  assign retrig = 1'b0;
`endif

  always_comb begin
    sc_d     = sample_clock;
    tick     = sample_clock & ~sc_q;
    sus_full = {sustain_level, {FRACBITS{1'b0}}};
    // One extra MSB catches carry on attack and borrow on decay/release.
    sum      = {1'b0, level_q} + {1'b0, attack_rate};
    dec      = {1'b0, level_q} - {1'b0, decay_rate};
    rel      = {1'b0, level_q} - {1'b0, release_rate};
    level_d  = level_q;
    st_d     = st_q;
    if (tick && retrig) begin
      level_d = '0;
      st_d    = S_ATTACK;
    end else if (tick) begin
      case (st_q)
        S_IDLE: if (gate) st_d = S_ATTACK;
        S_ATTACK: begin
          if (!gate) st_d = S_RELEASE;
          else if (sum[LW] || (&sum[LW-1:0])) begin
            level_d = '1;
            st_d    = S_DECAY;
          end else level_d = sum[LW-1:0];
        end
        S_DECAY: begin
          if (!gate) st_d = S_RELEASE;
          else if (dec[LW] || (dec[LW-1:0] <= sus_full)) begin
            level_d = sus_full;
            st_d    = S_SUSTAIN;
          end else level_d = dec[LW-1:0];
        end
        S_SUSTAIN: begin
          if (!gate) st_d = S_RELEASE;
          else       level_d = sus_full;
        end
        S_RELEASE: begin
          if (gate) st_d = S_ATTACK;
          else if (rel[LW] || (rel[LW-1:0] == '0)) begin
            level_d = '0;
            st_d    = S_IDLE;
          end else level_d = rel[LW-1:0];
        end
        default: begin
          level_d = '0;
          st_d    = S_IDLE;
        end
      endcase
    end
    busy_d = (st_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q    <= 1'b0;
      level_q <= '0;
      st_q    <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      sc_q    <= sc_d;
      level_q <= level_d;
      st_q    <= st_d;
      busy_q  <= busy_d;
    end
  end

  assign volume = level_q[LW-1:FRACBITS];
  assign state  = st_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Randomized bench for envelope_sequencer against an integer ADSR model.
module tb_envelope_sequencer;
  logic        clk = 1'b0;
  logic        rst, sample_clock, gate;
  logic [15:0] ar, dr, rr;
  logic [7:0]  sus;
  logic [7:0]  volume;
  logic [2:0]  state;
  logic        busy;

  int vecs = 0;
  int errs = 0;
  int m_lvl, m_st;
  bit m_pend, m_gate;

  envelope_sequencer #(.VOLBITS(8), .FRACBITS(8)) dut (
    .clk(clk), .rst(rst), .sample_clock(sample_clock), .gate(gate),
    .attack_rate(ar), .decay_rate(dr), .sustain_level(sus), .release_rate(rr),
    .volume(volume), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_vol"}, int'(volume), m_lvl / 256);
    chk({tag, "_st"}, int'(state), m_st);
    chk({tag, "_busy"}, int'(busy), (m_st != 0) ? 1 : 0);
  endtask

  // Envelope rules in plain integer arithmetic; state numbers as exported.
  task automatic model_tick();
    int s, r;
    s = int'(sus) * 256;
    if (m_pend) begin
      m_pend = 1'b0;
      m_lvl  = 0;
      m_st   = 1;
    end else begin
      case (m_st)
        0: if (m_gate) m_st = 1;
        1: if (!m_gate) m_st = 4;
           else begin
             r = m_lvl + int'(ar);
             if (r >= 65535) begin m_lvl = 65535; m_st = 2; end
             else m_lvl = r;
           end
        2: if (!m_gate) m_st = 4;
           else begin
             r = m_lvl - int'(dr);
             if (r <= s) begin m_lvl = s; m_st = 3; end
             else m_lvl = r;
           end
        3: if (!m_gate) m_st = 4;
           else m_lvl = s;
        default: if (m_gate) m_st = 1;
           else begin
             r = m_lvl - int'(rr);
             if (r <= 0) begin m_lvl = 0; m_st = 0; end
             else m_lvl = r;
           end
      endcase
    end
  endtask

  task automatic do_tick(input string tag);
    @(negedge clk) sample_clock = 1'b1;
    @(negedge clk);
    model_tick();
    check_out(tag);
    @(negedge clk) sample_clock = 1'b0;
    repeat (2) @(negedge clk);
    check_out({tag, "_hold"});
  endtask

  task automatic set_gate(input bit v);
    @(negedge clk);
`ifdef ENVELOPE_RETRIGGER_EN
    if (v && !m_gate) m_pend = 1'b1;
`endif
    gate   = v;
    m_gate = v;
    @(negedge clk);
  endtask

  task automatic gate_pulse();
    set_gate(1'b1);
    repeat (2) @(negedge clk);
    set_gate(1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; gate = 1'b0; m_gate = 1'b0;
    repeat (2) @(negedge clk);
    m_lvl = 0; m_st = 0; m_pend = 1'b0;
    check_out(tag);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_out({tag, "_after"});
  endtask

  task automatic run_until(input string tag, input int target_st, input int budget);
    int n = 0;
    while (m_st != target_st && n < budget) begin
      do_tick(tag);
      n++;
    end
    chk({tag, "_reached"}, m_st, target_st);
  endtask

  initial begin
    rst = 1'b1; gate = 1'b0; sample_clock = 1'b0;
    ar = '0; dr = '0; rr = '0; sus = '0;
    m_lvl = 0; m_st = 0; m_pend = 1'b0; m_gate = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vol", int'(volume), 0);
    chk("rst_st", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Attack ramp 0x10 per tick, clamp to full scale on tick 16.
    ar = 16'h1000; dr = 16'h0800; sus = 8'h80; rr = 16'h0400;
    set_gate(1'b1);
    do_tick("idle_to_atk");
    chk("atk_entry_st", int'(state), 1);
    for (int i = 1; i <= 16; i++) begin
      do_tick("atk");
      if (i <= 15) chk("atk_ramp", int'(volume), i * 16);
    end
    chk("atk_clamp_vol", int'(volume), 8'hFF);
    chk("atk_clamp_st", int'(state), 2);

    do_tick("dec1");
    chk("dec_first", int'(volume), 8'hF7);
    run_until("dec", 3, 40);
    chk("sus_vol", int'(volume), 8'h80);
    sus = 8'h40;
    do_tick("sus_live");
    chk("sus_live_vol", int'(volume), 8'h40);

    set_gate(1'b0);
    do_tick("rel_entry");
    chk("rel_entry_st", int'(state), 4);
    run_until("rel", 0, 40);
    chk("rel_done_busy", int'(busy), 0);

    // Reset mid-sustain.
    set_gate(1'b1);
    ar = 16'h2000;
    run_until("to_sus", 3, 60);
    do_reset("rst_mid");

    // Re-press during release at volume 0x20.
    ar = 16'h1000; sus = 8'h40;
    set_gate(1'b1);
    run_until("to_sus2", 3, 60);
    set_gate(1'b0);
    begin
      int n = 0;
      while (m_lvl != 16'h2000 && n < 40) begin do_tick("rel2"); n++; end
      chk("rel2_at_20", int'(volume), 8'h20);
    end
    set_gate(1'b1);
    do_tick("repress");
    chk("repress_st", int'(state), 1);
`ifdef ENVELOPE_RETRIGGER_EN
    chk("repress_vol", int'(volume), 8'h00);
    do_tick("repress2");
    chk("repress2_vol", int'(volume), 8'h10);
`else
    chk("repress_vol", int'(volume), 8'h20);
    do_tick("repress2");
    chk("repress2_vol", int'(volume), 8'h30);
`endif

    // Short gate pulse between ticks while idle.
    set_gate(1'b0);
    rr = 16'h2000;
    run_until("to_idle", 0, 60);
    gate_pulse();
    do_tick("pulse1");
`ifdef ENVELOPE_RETRIGGER_EN
    chk("pulse1_st", int'(state), 1);
    do_tick("pulse2");
    chk("pulse2_st", int'(state), 4);
`else
    chk("pulse1_st", int'(state), 0);
`endif

    // Randomized mix of ticks, gate activity, rate/sustain changes and resets.
    for (int it = 0; it < 500; it++) begin
      int a = $urandom_range(0, 99);
      if (a < 8) begin
        ar  = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
        dr  = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h2000));
        rr  = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h2000));
        case ($urandom_range(0, 3))
          0: sus = 8'h00;
          1: sus = 8'hFF;
          default: sus = 8'($urandom_range(0, 255));
        endcase
      end else if (a < 20) begin
        set_gate(!m_gate);
      end else if (a < 24) begin
        if (!m_gate) gate_pulse();
      end else if (a < 26) begin
        do_reset("rnd_rst");
      end else begin
        do_tick("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
